// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter fed by the PISO byte stream over a valid/ready handshake.
// Counts completed bytes and pulses block_done at the end of each AES block.
`timescale 1ns/1ps

module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT    = 434,
   parameter int unsigned BYTES_PER_BLOCK = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       byte_done,
   output logic       block_done
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CntW  = $clog2(BYTES_PER_BLOCK) + 1;

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntLast  = CntW'(BYTES_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [BaudW-1:0]  baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
   logic              tx_q, tx_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;
   logic              byte_done_q, byte_done_d;
   logic              block_done_q, block_done_d;
   logic              baud_last;

   assign baud_last = (baud_q == BaudLast);

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_cnt_d   = byte_cnt_q;
      tx_d         = tx_q;
      tx_ready_d   = tx_ready_q;
      busy_d       = busy_q;
      byte_done_d  = 1'b0;
      block_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tx_valid && tx_ready_q) begin
               state_d    = StStart;
               shift_d    = tx_data;
               baud_d     = '0;
               bit_idx_d  = '0;
               tx_d       = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end

         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = StData;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         StData: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  // Shift so the next bit to send always sits at shift_q[0].
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         StStop: begin
            if (baud_last) begin
               baud_d      = '0;
               state_d     = StIdle;
               tx_ready_d  = 1'b1;
               busy_d      = 1'b0;
               byte_done_d = 1'b1;
               if (byte_cnt_q == CntLast) begin
                  block_done_d = 1'b1;
                  byte_cnt_d   = '0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         baud_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_cnt_q   <= '0;
         tx_q         <= 1'b1;
         tx_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         byte_done_q  <= 1'b0;
         block_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_cnt_q   <= byte_cnt_d;
         tx_q         <= tx_d;
         tx_ready_q   <= tx_ready_d;
         busy_q       <= busy_d;
         byte_done_q  <= byte_done_d;
         block_done_q <= block_done_d;
      end
   end

   assign tx         = tx_q;
   assign tx_ready   = tx_ready_q;
   assign busy       = busy_q;
   assign byte_done  = byte_done_q;
   assign block_done = block_done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte with CLKS_PER_BIT=4, BYTES_PER_BLOCK=16.
// Line levels are compared cycle by cycle against hand-computed 10-bit frames.
`timescale 1ns/1ps

module tb_uart_tx_byte;

   localparam int unsigned Cpb = 4;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic       byte_done;
   logic       block_done;

   int checks;
   int errors;
   int model_cnt;

   uart_tx_byte #(
      .CLKS_PER_BIT   (Cpb),
      .BYTES_PER_BLOCK(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx        (tx),
      .busy      (busy),
      .byte_done (byte_done),
      .block_done(block_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame vectors: line levels in send order, MSB first: start, d0..d7, stop.
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] frame_of(input logic [7:0] d);
      logic [9:0] f;
      f[9] = 1'b0;
      for (int i = 0; i < 8; i++) f[8-i] = d[i];
      f[0] = 1'b1;
      return f;
   endfunction

   // Called from an IDLE sample point; accept happens on the next edge.
   task automatic send_frame(input logic [7:0] data, input logic [9:0] line, input bit hold,
                             input bit keep);
      logic exp_blk;
      chk("ready_before_accept", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = data;
      tick();
      exp_blk = (model_cnt == 15);
      if (!hold) tx_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < int'(Cpb); c++) begin
            if (hold) tx_data = 8'($urandom);
            chk($sformatf("line_%02h_lvl%0d_c%0d", data, i, c), tx, line[9-i]);
            chk("ready_low_in_frame", tx_ready, 0);
            chk("busy_in_frame", busy, 1);
            chk("no_byte_done_in_frame", byte_done, 0);
            chk("no_block_done_in_frame", block_done, 0);
            if (!(i == 9 && c == int'(Cpb) - 1)) tick();
         end
      end
      tick();
      chk($sformatf("byte_done_%02h", data), byte_done, 1);
      chk($sformatf("block_done_%02h", data), block_done, exp_blk);
      chk("ready_after_frame", tx_ready, 1);
      chk("busy_after_frame", busy, 0);
      chk("tx_idle_after_frame", tx, 1);
      model_cnt = (model_cnt == 15) ? 0 : model_cnt + 1;
      if (!keep) tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_byte_done", byte_done, 0);
      chk("rst_block_done", block_done, 0);
      repeat (3) tick();
      reset = 1'b1;
      model_cnt = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      model_cnt = 0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      reset     = 1'b1;

      vecs[0] = '{data: 8'h3C, line: 10'b0001111001};
      vecs[1] = '{data: 8'h00, line: 10'b0000000001};
      vecs[2] = '{data: 8'hFF, line: 10'b0111111111};
      vecs[3] = '{data: 8'h01, line: 10'b0100000001};
      vecs[4] = '{data: 8'h80, line: 10'b0000000011};
      vecs[5] = '{data: 8'h5A, line: 10'b0010110101};

      // Reset with tx_valid high: nothing accepted while held.
      tick();
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      reset    = 1'b0;
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_byte_done", byte_done, 0);
      chk("rst_block_done", block_done, 0);
      repeat (3) begin
         tick();
         chk("rst_hold_tx", tx, 1);
         chk("rst_hold_busy", busy, 0);
      end
      reset = 1'b1;

      // Accept on the first edge after release; A5 frame.
      send_frame(8'hA5, 10'b0101001011, 1'b0, 1'b0);

      // Table of back-to-back frames.
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].data, vecs[v].line, 1'b0, v != 5);
      end

      // Valid held with churning data while busy.
      send_frame(8'hC3, 10'b0110000111, 1'b1, 1'b1);
      send_frame(8'h5A, 10'b0010110101, 1'b1, 1'b0);
      tick();
      chk("idle_after_hold", busy, 0);

      // Full block from a clean counter, then a 17th byte.
      do_reset();
      tick();
      for (int b = 0; b < 16; b++) begin
         send_frame(8'(8'h10 + b), frame_of(8'(8'h10 + b)), 1'b0, 1'b1);
      end
      send_frame(8'h20, 10'b0000001001, 1'b0, 1'b0);
      tick();

      // Reset during data bit 3 of E7 (bit 3 is 0).
      tx_valid = 1'b1;
      tx_data  = 8'hE7;
      tick();
      tx_valid = 1'b0;
      repeat (18) tick();
      chk("mid_bit3_tx", tx, 0);
      chk("mid_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("abort_tx_high", tx, 1);
      chk("abort_ready", tx_ready, 1);
      chk("abort_busy", busy, 0);
      repeat (3) begin
         tick();
         chk("abort_no_byte_done", byte_done, 0);
         chk("abort_no_block_done", block_done, 0);
         chk("abort_tx", tx, 1);
      end
      reset     = 1'b1;
      model_cnt = 0;
      tick();
      chk("post_abort_ready", tx_ready, 1);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_no_byte_done", byte_done, 0);

      send_frame(8'h3C, 10'b0001111001, 1'b0, 1'b1);
      for (int b = 0; b < 15; b++) begin
         send_frame(8'(8'h40 + b), frame_of(8'(8'h40 + b)), 1'b0, b != 14);
      end
      tick();
      chk("final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
